// File: rtl/wb_buf_bridge_if.sv
// Bundle of the Wishbone classic slave signals and the buffer request/acknowledge
// port of wb_buf_bridge. The slave modport is the bridge; the master modport is its environment.
interface wb_buf_bridge_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [AW-1:0] WB_ADR_I;
    logic [DW-1:0] WB_DAT_I;
    logic [SW-1:0] WB_SEL_I;
    logic          WB_WE_I;
    logic          WB_CYC_I;
    logic          WB_STB_I;
    logic [DW-1:0] WB_DAT_O;
    logic          WB_ACK_O;
    logic          WB_ERR_O;
    logic          BUF_REQ;
    logic          BUF_WR;
    logic [AW-1:0] BUF_ADDR_O;
    logic [DW-1:0] BUF_DATA_O;
    logic [SW-1:0] BUF_BE_O;
    logic [DW-1:0] BUF_DATA_I;
    logic          BUF_ACK;

    modport slave (
        input  WB_ADR_I, WB_DAT_I, WB_SEL_I, WB_WE_I, WB_CYC_I, WB_STB_I,
        input  BUF_DATA_I, BUF_ACK,
        output WB_DAT_O, WB_ACK_O, WB_ERR_O,
        output BUF_REQ, BUF_WR, BUF_ADDR_O, BUF_DATA_O, BUF_BE_O
    );

    modport master (
        output WB_ADR_I, WB_DAT_I, WB_SEL_I, WB_WE_I, WB_CYC_I, WB_STB_I,
        output BUF_DATA_I, BUF_ACK,
        input  WB_DAT_O, WB_ACK_O, WB_ERR_O,
        input  BUF_REQ, BUF_WR, BUF_ADDR_O, BUF_DATA_O, BUF_BE_O
    );
endinterface

// File: rtl/wb_buf_bridge.sv
// Wishbone classic slave forwarding single read/write cycles to a request/acknowledge buffer port.
// Define WB_BUF_TIMEOUT_EN to terminate a stalled buffer access with WB_ERR_O after TMO_CYC clocks.
module wb_buf_bridge #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic           WB_CLK_I,
    input  logic           WB_RST_I,
    wb_buf_bridge_if.slave bus
);
    localparam int SW = DW / 8;

    if (((DW % 8) != 0) || (TMO_CYC < 1)) begin : g_cfg_check
        $error("wb_buf_bridge: DW must be a multiple of 8 and TMO_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] addr_r,  addr_s;
    logic [DW-1:0] wdat_r,  wdat_s;
    logic [SW-1:0] be_r,    be_s;
    logic          wr_r,    wr_s;
    logic          req_r,   req_s;
    logic          ack_r,   ack_s;
    logic [DW-1:0] rdat_r,  rdat_s;

`ifdef WB_BUF_TIMEOUT_EN
    localparam int            CW       = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    logic          err_r,     err_s;
    logic [CW-1:0] tmo_cnt_r, tmo_cnt_s;
`endif

    // Next-state and next-output logic; abort beats acknowledge, acknowledge beats timeout.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        wdat_s  = wdat_r;
        be_s    = be_r;
        wr_s    = wr_r;
        req_s   = req_r;
        ack_s   = 1'b0;
        rdat_s  = rdat_r;
`ifdef WB_BUF_TIMEOUT_EN
        err_s     = 1'b0;
        tmo_cnt_s = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.WB_CYC_I && bus.WB_STB_I) begin
                    addr_s  = bus.WB_ADR_I;
                    wdat_s  = bus.WB_DAT_I;
                    be_s    = bus.WB_SEL_I;
                    wr_s    = bus.WB_WE_I;
                    req_s   = 1'b1;
                    state_s = ST_REQ;
`ifdef WB_BUF_TIMEOUT_EN
                    tmo_cnt_s = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!bus.WB_CYC_I) begin
                    req_s   = 1'b0;
                    wr_s    = 1'b0;
                    state_s = ST_IDLE;
                end else if (bus.BUF_ACK) begin
                    req_s   = 1'b0;
                    ack_s   = 1'b1;
                    state_s = ST_RESP;
                    if (!wr_r) begin
                        rdat_s = bus.BUF_DATA_I;
                    end else begin
                        rdat_s = rdat_r;
                    end
`ifdef WB_BUF_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LAST) begin
                    req_s   = 1'b0;
                    err_s   = 1'b1;
                    state_s = ST_RESP;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CW'(1);
                end
`else
                end else begin
                    state_s = ST_REQ;
                end
`endif
            end
            ST_RESP: begin
                wr_s    = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                req_s   = 1'b0;
                wr_s    = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by WB_RST_I.
    always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
        if (WB_RST_I) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            wdat_r  <= '0;
            be_r    <= '0;
            wr_r    <= 1'b0;
            req_r   <= 1'b0;
            ack_r   <= 1'b0;
            rdat_r  <= '0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            wdat_r  <= wdat_s;
            be_r    <= be_s;
            wr_r    <= wr_s;
            req_r   <= req_s;
            ack_r   <= ack_s;
            rdat_r  <= rdat_s;
        end
    end

`ifdef WB_BUF_TIMEOUT_EN
    // Timeout counter and error flag.
    always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
        if (WB_RST_I) begin
            err_r     <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            err_r     <= err_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    assign bus.WB_ERR_O = err_r;
`else
    assign bus.WB_ERR_O = 1'b0;
`endif

    assign bus.WB_DAT_O   = rdat_r;
    assign bus.WB_ACK_O   = ack_r;
    assign bus.BUF_REQ    = req_r;
    assign bus.BUF_WR     = wr_r;
    assign bus.BUF_ADDR_O = addr_r;
    assign bus.BUF_DATA_O = wdat_r;
    assign bus.BUF_BE_O   = be_r;
endmodule
